// File: rtl/alu_op_sequencer.sv
// ALU control sequencer: accepts one instruction per handshake, runs IDLE->EXEC->WB.
// Optional retired-instruction counter enabled by ALU_SEQ_RETIRE_CNT_EN.
module alu_op_sequencer #(
  parameter int REG_SEL_W = 3,
  parameter int CNT_W     = 16
) (
  input  logic                 ClockInput,
  input  logic                 ResetN,
  input  logic                 InstrValid,
  input  logic [15:0]          InstrWord,
  output logic                 InstrReady,
  input  logic [3:0]           FlagIn,
  output logic                 AluEnable,
  output logic [2:0]           AluExtOpCode,
  output logic [1:0]           AluOperandSelect,
  output logic                 AluIsExtOperation,
  output logic                 AluUpdateFlag,
  output logic                 AluUpdateResult,
  output logic [REG_SEL_W-1:0] RegReadSelA,
  output logic [REG_SEL_W-1:0] RegReadSelB,
  output logic                 RegWriteEn,
  output logic [REG_SEL_W-1:0] RegWriteSel,
  output logic                 BranchTaken,
  output logic [11:0]          BranchTarget,
  output logic                 IllegalOp
`ifdef ALU_SEQ_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]     RetiredCount
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        rdy_q, rdy_d;
  logic        zf_q, zf_d;

  logic [3:0] cls;
  logic [2:0] ext;
  logic       ext_ok, illegal;
  logic       in_exec, in_wb;
  logic       unused_flags;

  assign unused_flags = ^FlagIn[3:1];
  assign cls     = ir_q[15:12];
  assign ext     = ir_q[11:9];
  assign ext_ok  = (ext == 3'd0) || (ext == 3'd1) || (ext == 3'd4)
                || (ext == 3'd5) || (ext == 3'd6);
  assign illegal = (cls >= 4'd7) || ((cls == 4'd1) && !ext_ok);
  assign in_exec = (state_q == S_EXEC);
  assign in_wb   = (state_q == S_WB);
  assign InstrReady = rdy_q;

  always_ff @(posedge ClockInput or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      rdy_q   <= 1'b0;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      rdy_q   <= rdy_d;
      zf_q    <= zf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    rdy_d   = rdy_q;
    zf_d    = zf_q;
    unique case (state_q)
      S_IDLE: begin
        if (InstrValid && rdy_q) begin
          state_d = S_EXEC;
          ir_d    = InstrWord;
          rdy_d   = 1'b0;
        end else begin
          rdy_d = 1'b1;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
        zf_d    = FlagIn[0];
      end
      S_WB: begin
        state_d = S_IDLE;
        rdy_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    AluEnable         = 1'b0;
    AluExtOpCode      = 3'd0;
    AluOperandSelect  = 2'd0;
    AluIsExtOperation = 1'b0;
    AluUpdateFlag     = 1'b0;
    AluUpdateResult   = 1'b0;
    RegReadSelA       = '0;
    RegReadSelB       = '0;
    RegWriteEn        = 1'b0;
    RegWriteSel       = '0;
    BranchTaken       = 1'b0;
    BranchTarget      = 12'd0;
    IllegalOp         = 1'b0;
    if (in_exec) begin
      IllegalOp = illegal;
      if (!illegal) begin
        AluEnable   = (cls != 4'd0);
        RegReadSelA = REG_SEL_W'(ir_q[5:3]);
        RegReadSelB = REG_SEL_W'(ir_q[2:0]);
        unique case (1'b1)
          (cls == 4'd1): begin
            AluIsExtOperation = 1'b1;
            AluExtOpCode      = ext;
            AluUpdateResult   = 1'b1;
            AluUpdateFlag     = 1'b1;
          end
          (cls == 4'd2): begin
            AluOperandSelect = 2'd1;
            AluUpdateResult  = 1'b1;
            AluUpdateFlag    = 1'b1;
          end
          (cls == 4'd3): begin
            AluOperandSelect = 2'd2;
            AluUpdateResult  = 1'b1;
            AluUpdateFlag    = 1'b1;
          end
          (cls == 4'd4): begin
            AluOperandSelect = 2'd3;
            AluUpdateResult  = 1'b1;
          end
          (cls == 4'd5): begin
            AluIsExtOperation = 1'b1;
            AluExtOpCode      = 3'b001;
            AluUpdateFlag     = 1'b1;
          end
          default: ;
        endcase
      end
    end
    if (in_wb && !illegal) begin
      if ((cls >= 4'd1) && (cls <= 4'd4)) begin
        RegWriteEn  = 1'b1;
        RegWriteSel = REG_SEL_W'(ir_q[8:6]);
      end
      // zero flag was captured on the EXEC->WB edge
      if ((cls == 4'd6) && zf_q) begin
        BranchTaken  = 1'b1;
        BranchTarget = ir_q[11:0];
      end
    end
  end

`ifdef ALU_SEQ_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign RetiredCount = cnt_q;
  assign cnt_d = (in_wb && !illegal) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge ClockInput or negedge ResetN) begin
    if (!ResetN) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed cases plus random
// instructions compared against a per-class behavioural model.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] word = '0;
  logic [3:0]  flag = '0;
  logic        ready, en, isext, updf, updr, wen, bt, ill;
  logic [2:0]  extop, sela, selb, wsel;
  logic [1:0]  opsel;
  logic [11:0] tgt;
`ifdef ALU_SEQ_RETIRE_CNT_EN
  logic [3:0]  rcnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_cnt = '0;

  typedef struct packed {
    logic       en, isext, ur, uf, ill, wen, bt;
    logic [2:0] op;
    logic [1:0] sel;
    logic [2:0] wsel;
    logic [11:0] tgt;
  } exp_t;

  alu_op_sequencer #(.REG_SEL_W(3), .CNT_W(4)) dut (
    .ClockInput(clk), .ResetN(rst_n),
    .InstrValid(valid), .InstrWord(word), .InstrReady(ready),
    .FlagIn(flag), .AluEnable(en), .AluExtOpCode(extop),
    .AluOperandSelect(opsel), .AluIsExtOperation(isext),
    .AluUpdateFlag(updf), .AluUpdateResult(updr),
    .RegReadSelA(sela), .RegReadSelB(selb),
    .RegWriteEn(wen), .RegWriteSel(wsel),
    .BranchTaken(bt), .BranchTarget(tgt), .IllegalOp(ill)
`ifdef ALU_SEQ_RETIRE_CNT_EN
    , .RetiredCount(rcnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected behaviour from the class table, written as plain rules.
  function automatic exp_t model(input logic [15:0] w, input logic zf);
    exp_t m;
    int c, e;
    bit legal_ext;
    m = '0;
    c = int'(w[15:12]);
    e = int'(w[11:9]);
    legal_ext = (e == 0) || (e == 1) || (e == 4) || (e == 5) || (e == 6);
    m.ill = (c >= 7) || (c == 1 && !legal_ext);
    if (!m.ill) begin
      m.en    = (c != 0);
      m.isext = (c == 1) || (c == 5);
      m.op    = (c == 1) ? 3'(e) : (c == 5) ? 3'd1 : 3'd0;
      m.sel   = (c == 2) ? 2'd1 : (c == 3) ? 2'd2 : (c == 4) ? 2'd3 : 2'd0;
      m.ur    = (c >= 1) && (c <= 4);
      m.uf    = (c == 1) || (c == 2) || (c == 3) || (c == 5);
      m.wen   = (c >= 1) && (c <= 4);
      m.wsel  = m.wen ? w[8:6] : 3'd0;
      m.bt    = (c == 6) && zf;
      m.tgt   = m.bt ? w[11:0] : 12'd0;
    end
    return m;
  endfunction

  task automatic chk_quiet(input string ph, input logic exp_ready);
    chk({ph, ".ready"}, ready, exp_ready);
    chk({ph, ".en"}, en, 0);
    chk({ph, ".extop"}, extop, 0);
    chk({ph, ".opsel"}, opsel, 0);
    chk({ph, ".isext"}, isext, 0);
    chk({ph, ".updf"}, updf, 0);
    chk({ph, ".updr"}, updr, 0);
    chk({ph, ".sela"}, sela, 0);
    chk({ph, ".selb"}, selb, 0);
    chk({ph, ".wen"}, wen, 0);
    chk({ph, ".wsel"}, wsel, 0);
    chk({ph, ".bt"}, bt, 0);
    chk({ph, ".tgt"}, tgt, 0);
    chk({ph, ".ill"}, ill, 0);
  endtask

  task automatic run(input logic [15:0] w, input logic zf);
    exp_t m;
    int c;
    m = model(w, zf);
    c = int'(w[15:12]);
    @(negedge clk);
    chk_quiet("idle", 1'b1);
`ifdef ALU_SEQ_RETIRE_CNT_EN
    chk("cnt", rcnt, exp_cnt);
`endif
    valid = 1'b1;
    word  = w;
    @(posedge clk);
    #1;
    word  = 16'($urandom);
    valid = 1'($urandom_range(0, 1));
    flag  = {3'($urandom), zf};
    @(negedge clk);
    chk("exec.ready", ready, 0);
    chk("exec.en", en, m.en);
    chk("exec.extop", extop, m.op);
    chk("exec.opsel", opsel, m.sel);
    chk("exec.isext", isext, m.isext);
    chk("exec.updr", updr, m.ur);
    chk("exec.updf", updf, m.uf);
    chk("exec.ill", ill, m.ill);
    chk("exec.wen", wen, 0);
    chk("exec.bt", bt, 0);
    if (c >= 1 && c <= 5 && !m.ill) begin
      chk("exec.sela", sela, w[5:3]);
      chk("exec.selb", selb, w[2:0]);
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
    flag  = 4'($urandom);
    @(negedge clk);
    chk("wb.ready", ready, 0);
    chk("wb.en", en, 0);
    chk("wb.updr", updr, 0);
    chk("wb.updf", updf, 0);
    chk("wb.ill", ill, 0);
    chk("wb.wen", wen, m.wen);
    chk("wb.wsel", wsel, m.wsel);
    chk("wb.bt", bt, m.bt);
    chk("wb.tgt", tgt, m.tgt);
    if (!m.ill) exp_cnt = exp_cnt + 4'd1;
  endtask

  initial begin
    flag = 4'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset", 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rel.ready_pre", ready, 0);
    @(posedge clk);
    #1;
    chk_quiet("rel", 1'b1);

    run(16'h1253, 1'b0);
    run(16'h5012, 1'b1);
    run(16'h6ABC, 1'b1);
    run(16'h6ABC, 1'b0);
    run(16'hF000, 1'b1);
    run(16'h1600, 1'b1);
    run(16'h0000, 1'b0);
    run(16'h4F3A, 1'b0);

    // reset while an INC is in EXEC: no write-back may follow
    @(negedge clk);
    valid = 1'b1;
    word  = 16'h2123;
    @(posedge clk);
    #1;
    valid = 1'b0;
    @(negedge clk);
    chk("inc.exec.en", en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_quiet("rst_mid", 1'b0);
    exp_cnt = '0;
    @(posedge clk);
    @(negedge clk);
    chk_quiet("rst_hold", 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk_quiet("rst_after", 1'b1);
    end

    for (int i = 0; i < 60; i++) begin
      logic [15:0] w;
      w = {4'($urandom_range(0, 9)), 12'($urandom)};
      run(w, 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    chk_quiet("final", 1'b1);
`ifdef ALU_SEQ_RETIRE_CNT_EN
    chk("final.cnt", rcnt, exp_cnt);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
